// File: rtl/pico_apb_bridge.sv
// rtl/pico_apb_bridge.sv - PicoRV32 native memory port to two-completer APB requester
// Decodes the APB window, runs one SETUP/ACCESS transfer with a pready timeout, returns data or error.
module pico_apb_bridge #(
  parameter logic [7:0]  APB_REGION     = 8'h10,
  parameter logic [3:0]  UART_ID        = 4'h0,
  parameter logic [3:0]  TIMER_ID       = 4'h1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [11:0] paddr,
  output logic [1:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata0,
  input  logic        pready0,
  input  logic        pslverr0,
  input  logic [31:0] prdata1,
  input  logic        pready1,
  input  logic        pslverr1
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [11:0]   paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pstrb_q, pstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          sel_ready;
  logic          sel_slverr;
  logic [31:0]   sel_prdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[19:12];

  // Only the completer that owns this transfer is ever listened to.
  assign sel_ready  = sel_q[0] ? pready0  : pready1;
  assign sel_slverr = sel_q[0] ? pslverr0 : pslverr1;
  assign sel_prdata = sel_q[0] ? prdata0  : prdata1;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid && mem_addr[31:24] == APB_REGION) begin
          paddr_d  = mem_addr[11:0];
          pwdata_d = mem_wdata;
          pstrb_d  = mem_wstrb;
          pwrite_d = |mem_wstrb;
          if (mem_addr[23:20] == UART_ID) begin
            sel_d   = 2'b01;
            state_d = S_SETUP;
          end else if (mem_addr[23:20] == TIMER_ID) begin
            sel_d   = 2'b10;
            state_d = S_SETUP;
          end else begin
            sel_d   = 2'b00;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          state_d = S_RESP;
          err_d   = sel_slverr;
          rdata_d = sel_slverr ? ERR_RDATA : (pwrite_q ? 32'h0 : sel_prdata);
        end else begin
          if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + 1'b1;
          end
          // This cycle is the TIMEOUT_CYCLES-th unanswered ACCESS cycle.
          if (int'(cnt_q) + 1 >= TIMEOUT_CYCLES) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sel_q    <= 2'b00;
      paddr_q  <= 12'h0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'h0;
      pstrb_q  <= 4'h0;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign psel      = (state_q == S_SETUP || state_q == S_ACCESS) ? sel_q : 2'b00;
  assign penable   = (state_q == S_ACCESS);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign mem_ready = (state_q == S_RESP);
  assign mem_err   = (state_q == S_RESP) && err_q;
  assign mem_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;

endmodule
